// File: rtl/ram_dump_uart.sv
// ram_dump_uart: on halt, takes over the CPU RAM debug port, reads NUM_WORDS
// words from byte address 0 upward and streams each one out on txd as an 8N1
// frame:
//   A5, addr[15:8], addr[7:0], data[31:24..7:0], chk
// chk is the two's complement of the six address/data bytes.
// After the last word, a single 0x5A terminator byte is sent.
// Optional feature macro: RAM_DUMP_SKIP_ZERO_EN -- when defined, all-zero
// words are read but not framed.
module ram_dump_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_WORDS    = 16384,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              halt,
    output logic              override_ctrl,
    output logic [ADDR_W-1:0] iaddr,
    output logic              iren,
    input  logic [31:0]       iload,
    input  logic              iwait,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_REQ, S_WAIT, S_CHECK, S_SEND, S_NEXT, S_TERM, S_DONE
    } state_t;

    // Two's complement of the address and data bytes (sync byte excluded).
    function automatic logic [7:0] frame_chk(input logic [15:0] a, input logic [31:0] d);
        logic [7:0] s;
        s = a[15:8] + a[7:0] + d[31:24] + d[23:16] + d[15:8] + d[7:0];
        return 8'h00 - s;
    endfunction

    // Byte n (0..7) of the frame for address a and data d.
    function automatic logic [7:0] frame_byte(input logic [3:0] n, input logic [15:0] a,
                                              input logic [31:0] d);
        logic [7:0] b;
        case (n)
            4'd0:    b = 8'hA5;
            4'd1:    b = a[15:8];
            4'd2:    b = a[7:0];
            4'd3:    b = d[31:24];
            4'd4:    b = d[23:16];
            4'd5:    b = d[15:8];
            4'd6:    b = d[7:0];
            4'd7:    b = frame_chk(a, d);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [3:0]         bcnt_r, bcnt_n;
    logic [31:0]        data_r, data_n;
    logic [ADDR_W-1:0]  iaddr_r, iaddr_n;
    logic               iren_r, override_r, busy_r, done_r;
    logic               active_n;
    logic [IDX_W+1:0]   byte_addr_s;
    logic [15:0]        frame_addr_s;

    // UART transmitter state; txd_r always holds the bit currently on the line.
    logic               tx_active_r;
    logic [8:0]         tx_shift_r;
    logic [BAUD_W-1:0]  tx_baud_r;
    logic [3:0]         tx_bit_r;
    logic               txd_r;
    logic               tx_bit_end_s, tx_ready_s, tx_start_s;
    logic [7:0]         tx_data_s;

    assign byte_addr_s  = {idx_r, 2'b00};
    assign frame_addr_s = 16'(byte_addr_s);
    assign tx_bit_end_s = tx_active_r && (tx_baud_r == BAUD_LAST);
    // Ready in the last cycle of a stop bit, so the next start bit follows with no gap.
    assign tx_ready_s   = !tx_active_r || (tx_bit_end_s && (tx_bit_r == 4'd9));

    // Serialiser: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_active_r <= 1'b0;
            tx_shift_r  <= 9'h1FF;
            tx_baud_r   <= '0;
            tx_bit_r    <= 4'd0;
            txd_r       <= 1'b1;
        end else if (tx_start_s) begin
            tx_active_r <= 1'b1;
            tx_shift_r  <= {1'b1, tx_data_s};
            tx_baud_r   <= '0;
            tx_bit_r    <= 4'd0;
            txd_r       <= 1'b0;
        end else if (tx_bit_end_s) begin
            tx_baud_r <= '0;
            if (tx_bit_r == 4'd9) begin
                tx_active_r <= 1'b0;
                txd_r       <= 1'b1;
            end else begin
                tx_bit_r   <= tx_bit_r + 4'd1;
                txd_r      <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
            end
        end else if (tx_active_r) begin
            tx_baud_r <= tx_baud_r + BAUD_W'(1);
        end
    end

    // Dump sequencer next-state logic; port outputs are derived from the next state.
    always_comb begin
        state_n    = state_r;
        idx_n      = idx_r;
        bcnt_n     = bcnt_r;
        data_n     = data_r;
        tx_start_s = 1'b0;
        tx_data_s  = 8'h00;
        case (state_r)
            S_IDLE: begin
                if (halt) state_n = S_ARM;
                else      state_n = S_IDLE;
            end
            S_ARM:  state_n = S_REQ;
            S_REQ:  state_n = S_WAIT;
            S_WAIT: begin
                if (!iwait) begin
                    data_n  = iload;
                    state_n = S_CHECK;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_CHECK: begin
                bcnt_n = 4'd0;
`ifdef RAM_DUMP_SKIP_ZERO_EN
                if (data_r == 32'h0000_0000) state_n = S_NEXT;
                else                         state_n = S_SEND;
`else
                state_n = S_SEND;
`endif
            end
            S_SEND: begin
                // After the 8th byte is loaded, wait for its stop bit before leaving.
                if (tx_ready_s) begin
                    if (bcnt_r == 4'd8) begin
                        state_n = S_NEXT;
                    end else begin
                        tx_start_s = 1'b1;
                        tx_data_s  = frame_byte(bcnt_r, frame_addr_s, data_r);
                        bcnt_n     = bcnt_r + 4'd1;
                    end
                end else begin
                    state_n = S_SEND;
                end
            end
            S_NEXT: begin
                bcnt_n = 4'd0;
                if (idx_r == IDX_LAST) begin
                    state_n = S_TERM;
                end else begin
                    idx_n   = idx_r + IDX_W'(1);
                    state_n = S_REQ;
                end
            end
            S_TERM: begin
                if (tx_ready_s) begin
                    if (bcnt_r == 4'd0) begin
                        tx_start_s = 1'b1;
                        tx_data_s  = 8'h5A;
                        bcnt_n     = 4'd1;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    state_n = S_TERM;
                end
            end
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        active_n = (state_n != S_IDLE) && (state_n != S_DONE);
        if (state_n == S_REQ) iaddr_n = ADDR_W'({idx_n, 2'b00});
        else                  iaddr_n = iaddr_r;
    end

    // Sequencer state and registered port outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= S_IDLE;
            idx_r      <= '0;
            bcnt_r     <= 4'd0;
            data_r     <= 32'h0000_0000;
            iaddr_r    <= '0;
            iren_r     <= 1'b0;
            override_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            idx_r      <= idx_n;
            bcnt_r     <= bcnt_n;
            data_r     <= data_n;
            iaddr_r    <= iaddr_n;
            iren_r     <= (state_n == S_REQ);
            override_r <= active_n;
            busy_r     <= active_n;
            done_r     <= (state_n == S_DONE);
        end
    end

    assign override_ctrl = override_r;
    assign iaddr         = iaddr_r;
    assign iren          = iren_r;
    assign txd           = txd_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Testbench for ram_dump_uart with CLKS_PER_BIT=4 and NUM_WORDS=4.
// A RAM model answers reads one cycle after iren, with an optional stall.
// A UART monitor decodes txd and checks that every bit is exactly 4 cycles wide.
// Expected bytes are queued when a dump is launched, then compared in order.
module tb_ram_dump_uart;
    localparam int CPB = 4;
    localparam int NW  = 4;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          halt = 1'b0;
    logic          iwait = 1'b1;
    logic [31:0]   iload = 32'hBAD0_BAD0;
    logic          override_ctrl, iren, txd, busy, done;
    logic [AW-1:0] iaddr;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] mem [0:NW-1];
    logic [7:0]  exp_q [$];
    logic [8:0]  rx_q [$];
    logic [31:0] addr_q [$];
    int iren_long = 0;
    int stall_idx = -1, stall_len = 0;
    int stall_seen = 0, stall_txd_bad = 0, stall_busy_bad = 0;
    int halt_cyc = 0, first_start_cyc = -1;

    ram_dump_uart #(.CLKS_PER_BIT(CPB), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
        .clk(clk), .nrst(nrst), .halt(halt), .override_ctrl(override_ctrl),
        .iaddr(iaddr), .iren(iren), .iload(iload), .iwait(iwait),
        .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RAM model: records every request and returns data one cycle later.
    // A stall can be added on a chosen word.
    logic        pend = 1'b0, prev_iren = 1'b0;
    int          stall_left = 0;
    logic [31:0] req_addr = 32'h0;
    always @(negedge clk) begin
        if (!nrst) begin
            pend = 1'b0; prev_iren = 1'b0; iwait = 1'b1; iload = 32'hBAD0_BAD0;
        end else begin
            if (iren === 1'b1) begin
                addr_q.push_back(iaddr);
                if (prev_iren) iren_long++;
                pend = 1'b1;
                req_addr = iaddr;
                stall_left = (int'(iaddr >> 2) == stall_idx) ? stall_len : 0;
                iwait = 1'b1; iload = 32'hBAD0_BAD0;
            end else if (pend && stall_left > 0) begin
                stall_left--;
                stall_seen++;
                if (txd !== 1'b1) stall_txd_bad++;
                if (busy !== 1'b1) stall_busy_bad++;
                iwait = 1'b1; iload = 32'hC0DE_0000 + 32'(cyc);
            end else if (pend) begin
                iwait = 1'b0; iload = mem[req_addr[3:2]]; pend = 1'b0;
            end else begin
                iwait = 1'b1; iload = 32'hBAD0_BAD0;
            end
            prev_iren = (iren === 1'b1);
        end
    end

    // UART monitor: 4 samples per bit; a bit that changes inside its window
    // or a bad stop bit marks the byte as badly framed.
    int         rx_cnt = -1, rx_total = 0;
    logic [9:0] rx_bits = 10'h3FF;
    logic       rx_err = 1'b0;
    always @(negedge clk) begin
        if (!nrst) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (txd === 1'b0) begin
                rx_bits[0] = 1'b0; rx_err = 1'b0; rx_cnt = 1;
                if (first_start_cyc < 0) first_start_cyc = cyc;
            end
        end else begin
            if (rx_cnt % 4 == 0) rx_bits[rx_cnt / 4] = txd;
            else if (txd !== rx_bits[rx_cnt / 4]) rx_err = 1'b1;
            rx_cnt++;
            if (rx_cnt == 40) begin
                if (rx_bits[9] !== 1'b1) rx_err = 1'b1;
                rx_q.push_back({rx_err, rx_bits[8:1]});
                rx_total++;
                rx_cnt = -1;
            end
        end
    end

    task automatic push_expected();
        for (int i = 0; i < NW; i++) begin
            logic [31:0] d;
            logic [15:0] a;
            int s;
            d = mem[i];
            a = 16'(i * 4);
`ifdef RAM_DUMP_SKIP_ZERO_EN
            if (d == 32'h0) continue;
`endif
            s = int'(a[15:8]) + int'(a[7:0]) + int'(d[31:24]) + int'(d[23:16])
              + int'(d[15:8]) + int'(d[7:0]);
            exp_q.push_back(8'hA5);
            exp_q.push_back(a[15:8]);
            exp_q.push_back(a[7:0]);
            exp_q.push_back(d[31:24]);
            exp_q.push_back(d[23:16]);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
            exp_q.push_back(8'((256 - (s % 256)) % 256));
        end
        exp_q.push_back(8'h5A);
    endtask

    task automatic apply_reset();
        nrst = 1'b0; halt = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    // One full dump. With restart=1, nrst is released with halt already high
    // instead of halt being pulsed.
    task automatic run_dump(input string tag, input int sidx, input int slen, input bit restart);
        int k;
        int n_exp;
        exp_q.delete(); rx_q.delete(); addr_q.delete();
        iren_long = 0; first_start_cyc = -1;
        stall_seen = 0; stall_txd_bad = 0; stall_busy_bad = 0;
        stall_idx = sidx; stall_len = slen;
        push_expected();
        n_exp = exp_q.size();
        if (restart) begin
            halt = 1'b1; nrst = 1'b1; halt_cyc = cyc;
            @(negedge clk);
        end else begin
            halt = 1'b1; halt_cyc = cyc;
            @(negedge clk);
        end
        halt = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 6000) begin @(negedge clk); k++; end
        n_vec++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL %s done_timeout: done=%b want 1", tag, done); end
        repeat (8) @(negedge clk);
        n_vec++;
        if (rx_q.size() != n_exp) begin
            n_bad++; $display("FAIL %s byte_count: got %0d want %0d", tag, rx_q.size(), n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            logic [7:0] e;
            logic [8:0] r;
            e = exp_q.pop_front();
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1XX;
            n_vec++;
            if (r !== {1'b0, e}) begin
                n_bad++; $display("FAIL %s byte%0d: got %h (frame_err=%b) want %h", tag, i, r[7:0], r[8], e);
            end
        end
        n_vec++;
        if (addr_q.size() != NW || iren_long != 0) begin
            n_bad++; $display("FAIL %s iren_pulses: got %0d reads (%0d long) want %0d single-cycle", tag, addr_q.size(), iren_long, NW);
        end
        for (int i = 0; i < NW && i < addr_q.size(); i++) begin
            n_vec++;
            if (addr_q[i] !== 32'(i * 4)) begin
                n_bad++; $display("FAIL %s iaddr%0d: got %h want %h", tag, i, addr_q[i], 32'(i * 4));
            end
        end
        n_vec++;
        if (first_start_cyc < 0 || first_start_cyc - halt_cyc > 15) begin
            n_bad++; $display("FAIL %s start_latency: got %0d cycles want <=15", tag, first_start_cyc - halt_cyc);
        end
        n_vec++;
        if ({done, override_ctrl, busy, txd, iren} !== 5'b10010) begin
            n_bad++; $display("FAIL %s end_state: got done/ovr/busy/txd/iren=%b want 10010", tag, {done, override_ctrl, busy, txd, iren});
        end
        if (slen > 0) begin
            n_vec++;
            if (stall_seen != slen || stall_txd_bad != 0 || stall_busy_bad != 0) begin
                n_bad++; $display("FAIL %s stall: got %0d stall cycles, txd_bad=%0d busy_bad=%0d want %0d,0,0", tag, stall_seen, stall_txd_bad, stall_busy_bad, slen);
            end
        end
        stall_idx = -1; stall_len = 0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; halt = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({override_ctrl, iren, txd, busy, done} !== 5'b00100 || iaddr !== '0) begin
            n_bad++; $display("FAIL reset: got ovr/iren/txd/busy/done=%b iaddr=%h want 00100 0", {override_ctrl, iren, txd, busy, done}, iaddr);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        apply_reset();
        run_dump("dump", -1, 0, 1'b0);
    endtask

    task automatic test_iwait_stall();
        apply_reset();
        run_dump("stall", 2, 50, 1'b0);
    endtask

    task automatic test_no_restart();
        rx_q.delete(); addr_q.delete();
        halt = 1'b0; @(negedge clk);
        halt = 1'b1;
        repeat (200) @(negedge clk);
        halt = 1'b0;
        n_vec++;
        if (rx_q.size() != 0 || addr_q.size() != 0 || done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            n_bad++; $display("FAIL no_restart: got bytes=%0d reads=%0d done=%b busy=%b txd=%b want 0 0 1 0 1", rx_q.size(), addr_q.size(), done, busy, txd);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        apply_reset();
        rx_q.delete(); addr_q.delete();
        halt = 1'b1;
        k = 0;
        while (!(rx_total % 1000 == 0 && 0 == 1) && !(rx_q.size() == 3 && rx_cnt == 13) && k < 3000) begin
            @(negedge clk); k++;
        end
        n_vec++;
        if (k >= 3000) begin n_bad++; $display("FAIL mid_reset_reach: got timeout want byte4 data bit3"); end
        nrst = 1'b0;
        #1;
        n_vec++;
        if ({override_ctrl, iren, txd, busy, done} !== 5'b00100 || iaddr !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got ovr/iren/txd/busy/done=%b iaddr=%h want 00100 0", {override_ctrl, iren, txd, busy, done}, iaddr);
        end
        repeat (3) @(negedge clk);
        run_dump("restart", -1, 0, 1'b1);
    endtask

    initial begin
        mem[0] = 32'h1234_5678;
        mem[1] = 32'h0000_0000;
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'h0000_0000;
        test_reset();
        test_full_dump();
        test_no_restart();
        test_iwait_stall();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
